lane_to_byte_demapper: RTL and testbench

//  RX-side inverse of the MB byte-to-lane mapper. Collects 32-bit per-lane words from
//  16 (or 8 degraded) receive lanes over consecutive valid beats and reassembles them

---
 rtl/lane_to_byte_demapper_if.sv | 23 ++
 rtl/lane_to_byte_demapper.sv | 106 ++++++++++
 tb/tb_lane_to_byte_demapper.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_to_byte_demapper_if.sv
// Lane-side and flit-side signals of the RX lane-to-byte demapper.
interface lane_to_byte_demapper_if #(
    parameter int WIDTH     = 32,
    parameter int N_BYTES   = 1024,
    parameter int NUM_LANES = 16
);
    logic                            enable_demapper;
    logic [1:0]                      functional_rx_lanes;
    logic                            lane_valid;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane;
    logic [8*N_BYTES-1:0]            out_data;
    logic                            out_valid;
    logic                            busy;

    modport master (
        output enable_demapper, functional_rx_lanes, lane_valid, lane,
        input  out_data, out_valid, busy
    );
    modport slave (
        input  enable_demapper, functional_rx_lanes, lane_valid, lane,
        output out_data, out_valid, busy
    );
endinterface

// File: rtl/lane_to_byte_demapper.sv
// Reassembles per-lane RX words into one N_BYTES flit; inverse of the TX byte-to-lane mapper.
module lane_to_byte_demapper #(
    parameter int WIDTH     = 32,
    parameter int N_BYTES   = 1024,
    parameter int NUM_LANES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    lane_to_byte_demapper_if.slave   bus
);
    localparam int FLIT_W     = 8 * N_BYTES;
    localparam int CHUNKS     = FLIT_W / WIDTH;
    localparam int HALF       = NUM_LANES / 2;
    localparam int BEATS_HALF = CHUNKS / HALF;
    localparam int BEATS_FULL = CHUNKS / NUM_LANES;
    localparam int CNT_W      = $clog2(BEATS_HALF);
    localparam int IDX_W      = $clog2(CHUNKS);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_eff;
    logic [CNT_W-1:0]   count_q, last_idx;
    logic [IDX_W-1:0]   base;
    logic [FLIT_W-1:0]  acc_q, acc_d, out_q;
    logic               out_valid_q;
    logic               capture, last, abort;

    // Beat 0 is captured from IDLE, before the mode has been latched.
    assign mode_eff = (state_q == IDLE) ? bus.functional_rx_lanes : mode_q;
    assign last_idx = (mode_q == 2'b11) ? CNT_W'(BEATS_FULL - 1) : CNT_W'(BEATS_HALF - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        last    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable_demapper && bus.lane_valid && bus.functional_rx_lanes != 2'b00) begin
                    capture = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!bus.enable_demapper) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (bus.lane_valid) begin
                    capture = 1'b1;
                    if (count_q == last_idx) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Chunk index of lane slot j at beat k is k*L + j.
    always_comb begin
        acc_d = acc_q;
        base  = '0;
        if (mode_eff == 2'b11) begin
            base = IDX_W'(count_q) << $clog2(NUM_LANES);
            for (int j = 0; j < NUM_LANES; j++)
                acc_d[(int'(base) + j) * WIDTH +: WIDTH] = bus.lane[j];
        end else begin
            base = IDX_W'(count_q) << $clog2(HALF);
            for (int j = 0; j < HALF; j++)
                acc_d[(int'(base) + j) * WIDTH +: WIDTH] =
                    (mode_eff == 2'b10) ? bus.lane[j + HALF] : bus.lane[j];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q     <= '0;
            mode_q      <= 2'b00;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= last;
            if (abort) begin
                count_q <= '0;
                acc_q   <= '0;
            end else if (capture) begin
                acc_q   <= acc_d;
                count_q <= last ? '0 : count_q + 1'b1;
                if (state_q == IDLE) mode_q <= bus.functional_rx_lanes;
                if (last)            out_q  <= acc_d;
            end
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == COLLECT);
endmodule

// File: tb/tb_lane_to_byte_demapper.sv
// Randomized bench for lane_to_byte_demapper against a TX-mapper based flit model.
module tb_lane_to_byte_demapper;
    localparam int W  = 32;
    localparam int NB = 1024;
    localparam int NL = 16;
    localparam int FW = 8 * NB;
    localparam int CH = FW / W;

    typedef logic [FW-1:0]         flit_t;
    typedef logic [NL-1:0][W-1:0]  lanes_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_to_byte_demapper_if #(.WIDTH(W), .N_BYTES(NB), .NUM_LANES(NL)) bus ();
    lane_to_byte_demapper #(.WIDTH(W), .N_BYTES(NB), .NUM_LANES(NL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    flit_t pq[$];
    int    pc[$];
    flit_t last_exp = '0;
    flit_t pat_exp;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.out_valid === 1'b1) begin
        pq.push_back(bus.out_data);
        pc.push_back(cyc);
    end

    // TX mapper: chunk k*L+j goes to lane j (01, 11) or lane 8+j (10); idle lanes carry filler.
    function automatic lanes_t tx_map(input flit_t f, input logic [1:0] m, input int k);
        lanes_t l;
        for (int j = 0; j < NL; j++) l[j] = 32'hDEADBEEF;
        if (m == 2'b11) for (int j = 0; j < 16; j++) l[j] = f[(16*k + j)*W +: W];
        else            for (int j = 0; j < 8; j++)  l[(m == 2'b10) ? j + 8 : j] = f[(8*k + j)*W +: W];
        return l;
    endfunction

    function automatic flit_t rand_flit();
        flit_t f;
        for (int c = 0; c < CH; c++) f[c*W +: W] = $urandom;
        return f;
    endfunction

    function automatic int first_diff(input flit_t a, input flit_t b);
        for (int c = 0; c < CH; c++) if (a[c*W +: W] !== b[c*W +: W]) return c;
        return 0;
    endfunction

    task automatic drive(input logic en, input logic [1:0] m, input logic v, input lanes_t l);
        @(negedge clk);
        bus.enable_demapper     = en;
        bus.functional_rx_lanes = m;
        bus.lane_valid          = v;
        bus.lane                = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 2'b00, 1'b0, '0);
    endtask

    task automatic settle(input int want);
        for (int i = 0; i < 40 && pq.size() < want; i++) begin @(negedge clk); #1; end
        #1;
    endtask

    task automatic run_frame(input flit_t f, input logic [1:0] m);
        for (int k = 0; k < ((m == 2'b11) ? 16 : 32); k++) drive(1'b1, m, 1'b1, tx_map(f, m, k));
        idle(1);
    endtask

    task automatic test_reset();
        bus.enable_demapper = 0; bus.functional_rx_lanes = 0; bus.lane_valid = 0; bus.lane = '0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.out_data !== '0) $display("FAIL reset out_data: got nonzero chunk0 %h want 0", bus.out_data[W-1:0]); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else passed++;
        rst_n = 1;
        idle(2);
    endtask

    task automatic test_pattern16();
        flit_t got;
        int d;
        pq.delete(); pc.delete();
        for (int k = 0; k < 16; k++) begin
            lanes_t l;
            for (int j = 0; j < 16; j++) begin
                l[j] = {8'hC0, 8'(k), 8'(j), 8'h5A};
                pat_exp[(16*k + j)*W +: W] = {8'hC0, 8'(k), 8'(j), 8'h5A};
            end
            drive(1'b1, 2'b11, 1'b1, l);
        end
        idle(1);
        settle(1);
        checks++; if (pq.size() != 1) $display("FAIL pattern16 pulses: got %0d want 1", pq.size()); else passed++;
        got = (pq.size() > 0) ? pq[0] : '0;
        d = first_diff(got, pat_exp);
        checks++; if (got !== pat_exp) $display("FAIL pattern16 data: chunk %0d got %h want %h", d, got[d*W +: W], pat_exp[d*W +: W]); else passed++;
        last_exp = pat_exp;
    endtask

    task automatic test_mode8();
        for (int mi = 0; mi < 2; mi++) begin
            logic [1:0] m;
            flit_t exp, got;
            int d, found;
            m = mi ? 2'b10 : 2'b01;
            pq.delete(); pc.delete();
            for (int k = 0; k < 32; k++) begin
                lanes_t l;
                for (int j = 0; j < NL; j++) l[j] = 32'hDEADBEEF;
                for (int j = 0; j < 8; j++) begin
                    l[mi ? j + 8 : j] = {16'(k), 16'(j)};
                    exp[(8*k + j)*W +: W] = {16'(k), 16'(j)};
                end
                drive(1'b1, m, 1'b1, l);
            end
            idle(1);
            settle(1);
            checks++; if (pq.size() != 1) $display("FAIL mode8_%0d pulses: got %0d want 1", m, pq.size()); else passed++;
            got = (pq.size() > 0) ? pq[0] : '0;
            d = first_diff(got, exp);
            checks++; if (got !== exp) $display("FAIL mode8_%0d data: chunk %0d got %h want %h", m, d, got[d*W +: W], exp[d*W +: W]); else passed++;
            found = 0;
            for (int c = 0; c < CH; c++) if (got[c*W +: W] == 32'hDEADBEEF) found++;
            checks++; if (found != 0) $display("FAIL mode8_%0d filler: got %0d DEADBEEF chunks want 0", m, found); else passed++;
            last_exp = exp;
        end
    endtask

    task automatic test_loopback();
        logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            flit_t f, got;
            int d;
            f = rand_flit();
            pq.delete(); pc.delete();
            run_frame(f, modes[i]);
            settle(1);
            checks++; if (pq.size() != 1) $display("FAIL loopback_%0d pulses: got %0d want 1", modes[i], pq.size()); else passed++;
            got = (pq.size() > 0) ? pq[0] : '0;
            d = first_diff(got, f);
            checks++; if (got !== f) $display("FAIL loopback_%0d data: chunk %0d got %h want %h", modes[i], d, got[d*W +: W], f[d*W +: W]); else passed++;
            last_exp = f;
        end
    endtask

    task automatic test_bubbles();
        flit_t got;
        int start, d;
        pq.delete(); pc.delete();
        start = 0;
        for (int s = 0; s < 31; s++) begin
            lanes_t l;
            for (int j = 0; j < NL; j++) l[j] = (s % 2 == 0) ? pat_exp[(16*(s/2) + j)*W +: W] : $urandom;
            drive(1'b1, 2'b11, (s % 2 == 0), l);
            if (s == 0) start = cyc;
        end
        idle(1);
        settle(1);
        checks++; if (pq.size() != 1) $display("FAIL bubbles pulses: got %0d want 1", pq.size()); else passed++;
        got = (pq.size() > 0) ? pq[0] : '0;
        d = first_diff(got, pat_exp);
        checks++; if (got !== pat_exp) $display("FAIL bubbles data: chunk %0d got %h want %h", d, got[d*W +: W], pat_exp[d*W +: W]); else passed++;
        // 31 input cycles (1..31), pulse in the cycle right after the last beat
        checks++; if (pc.size() < 1 || pc[0] - start + 1 != 32) $display("FAIL bubbles latency: got cycle %0d want 32", (pc.size() > 0) ? pc[0] - start + 1 : -1); else passed++;
        last_exp = pat_exp;
    endtask

    task automatic test_abort();
        flit_t fa, fb, got;
        int d;
        fa = rand_flit();
        fb = rand_flit();
        pq.delete(); pc.delete();
        for (int k = 0; k < 9; k++) drive(1'b1, 2'b11, 1'b1, tx_map(fa, 2'b11, k));
        drive(1'b0, 2'b11, 1'b1, tx_map(fa, 2'b11, 9));
        idle(3);
        #1;
        checks++; if (pq.size() != 0) $display("FAIL abort pulses: got %0d want 0", pq.size()); else passed++;
        d = first_diff(bus.out_data, last_exp);
        checks++; if (bus.out_data !== last_exp) $display("FAIL abort hold: chunk %0d got %h want %h", d, bus.out_data[d*W +: W], last_exp[d*W +: W]); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort busy: got %b want 0", bus.busy); else passed++;
        run_frame(fb, 2'b11);
        settle(1);
        checks++; if (pq.size() != 1) $display("FAIL abort_new pulses: got %0d want 1", pq.size()); else passed++;
        got = (pq.size() > 0) ? pq[0] : '0;
        d = first_diff(got, fb);
        checks++; if (got !== fb) $display("FAIL abort_new data: chunk %0d got %h want %h", d, got[d*W +: W], fb[d*W +: W]); else passed++;
        last_exp = fb;
    endtask

    task automatic test_back_to_back();
        flit_t f1, f2, g1, g2;
        int start, d;
        f1 = rand_flit();
        f2 = rand_flit();
        pq.delete(); pc.delete();
        start = 0;
        for (int k = 0; k < 32; k++) begin
            // mode input switches to 01 from beat 5 of frame 1; must not affect that frame
            drive(1'b1, (k >= 5 && k < 16) ? 2'b01 : 2'b11, 1'b1, tx_map((k < 16) ? f1 : f2, 2'b11, k % 16));
            if (k == 0) start = cyc;
        end
        idle(1);
        settle(2);
        checks++; if (pq.size() != 2) $display("FAIL b2b pulses: got %0d want 2", pq.size()); else passed++;
        g1 = (pq.size() > 0) ? pq[0] : '0;
        g2 = (pq.size() > 1) ? pq[1] : '0;
        d = first_diff(g1, f1);
        checks++; if (g1 !== f1) $display("FAIL b2b data1: chunk %0d got %h want %h", d, g1[d*W +: W], f1[d*W +: W]); else passed++;
        d = first_diff(g2, f2);
        checks++; if (g2 !== f2) $display("FAIL b2b data2: chunk %0d got %h want %h", d, g2[d*W +: W], f2[d*W +: W]); else passed++;
        checks++; if (pc.size() < 1 || pc[0] - start + 1 != 17) $display("FAIL b2b cycle1: got %0d want 17", (pc.size() > 0) ? pc[0] - start + 1 : -1); else passed++;
        checks++; if (pc.size() < 2 || pc[1] - start + 1 != 33) $display("FAIL b2b cycle2: got %0d want 33", (pc.size() > 1) ? pc[1] - start + 1 : -1); else passed++;
        last_exp = f2;
    endtask

    task automatic test_mode00();
        pq.delete(); pc.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b00, 1'b1, tx_map(rand_flit(), 2'b11, 0));
        idle(2);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL mode00 busy: got %b want 0", bus.busy); else passed++;
        checks++; if (pq.size() != 0) $display("FAIL mode00 pulses: got %0d want 0", pq.size()); else passed++;
    endtask

    task automatic test_async_reset();
        flit_t f, got;
        int d;
        f = rand_flit();
        for (int k = 0; k < 5; k++) drive(1'b1, 2'b11, 1'b1, tx_map(f, 2'b11, k));
        #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL arst pre busy: got %b want 1", bus.busy); else passed++;
        #1 rst_n = 0;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL arst busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.out_data !== '0) $display("FAIL arst out_data: got chunk0 %h want 0", bus.out_data[W-1:0]); else passed++;
        idle(1);
        rst_n = 1;
        idle(1);
        pq.delete(); pc.delete();
        f = rand_flit();
        run_frame(f, 2'b01);
        settle(1);
        got = (pq.size() > 0) ? pq[0] : '0;
        d = first_diff(got, f);
        checks++; if (pq.size() != 1 || got !== f) $display("FAIL arst recover: pulses %0d chunk %0d got %h want %h", pq.size(), d, got[d*W +: W], f[d*W +: W]); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pattern16();
        test_mode8();
        test_loopback();
        test_bubbles();
        test_abort();
        test_back_to_back();
        test_mode00();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
